instruction_sequencer: RTL

Front end of the CPU control unit. It latches each fetched opcode into the instruction register and generates the one-hot T-state step and M-cycle count. It decodes the opcode into the one-hot X/Y/Z/P/Q fields consumed by the X0–X3 and CB decoder blocks, and acts on the decoders' OR-combined fetch, cycle-reset, EI/DI and CB-prefix requests. It also owns the interrupt master enable (IME) and the interrupt-dispatch entry decision.

---
 rtl/instruction_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// Control-unit front end: T-state/M-cycle sequencing, instruction register,
// one-hot opcode field decode, IME handling and interrupt-dispatch entry.
module instruction_sequencer (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Stall,
    input  logic [7:0] i_Data,
    input  logic       i_Fetch,
    input  logic       i_Reset_Cycle,
    input  logic       i_EI,
    input  logic       i_DI,
    input  logic       i_CB_Prefix,
    input  logic       i_Int_Request,
    output logic [3:0] o_Cycle_Step,
    output logic [7:0] o_Cycle_Count,
    output logic [7:0] o_IR,
    output logic [3:0] o_X_Active,
    output logic       o_CB_Active,
    output logic [7:0] o_Y,
    output logic [7:0] o_Z,
    output logic [3:0] o_P,
    output logic [1:0] o_Q,
    output logic       o_CB_Mode,
    output logic       o_IME,
    output logic       o_Int_Dispatch,
    output logic       o_Count_Error
);

    logic [3:0] r_step;
    logic [7:0] r_count;
    logic [7:0] r_ir;
    logic       r_cb_mode;
    logic       r_ime;
    logic       r_ei_pending;
    logic       r_int_dispatch;
    logic       r_count_error;

    logic       w_take_int;
    logic [3:0] w_x_active;

    // Interrupt entry is decided on the IME value held before this boundary.
    assign w_take_int = r_ime & i_Int_Request & ~i_CB_Prefix;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; later assignments in the block take priority.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_step         <= 4'b0001;
            r_count        <= 8'h01;
            r_ir           <= 8'h00;
            r_cb_mode      <= 1'b0;
            r_ime          <= 1'b0;
            r_ei_pending   <= 1'b0;
            r_int_dispatch <= 1'b0;
            r_count_error  <= 1'b0;
        end else if (!i_Stall) begin
            r_step <= {r_step[2:0], r_step[3]};
            if (r_step[3]) begin
                if (i_Fetch) begin
                    r_count <= 8'h01;
                    if (w_take_int) begin
                        r_int_dispatch <= 1'b1;
                        r_cb_mode      <= 1'b0;
                    end else begin
                        r_ir           <= i_Data;
                        r_int_dispatch <= 1'b0;
                        r_cb_mode      <= i_CB_Prefix;
                    end
                end else if (i_Reset_Cycle) begin
                    r_count <= 8'h01;
                end else if (r_count[7]) begin
                    r_count_error <= 1'b1;
                end else begin
                    r_count <= {r_count[6:0], 1'b0};
                end

                if (i_DI) begin
                    r_ime        <= 1'b0;
                    r_ei_pending <= 1'b0;
                end else begin
                    if (i_Fetch) begin
                        if (w_take_int) begin
                            r_ime <= 1'b0;
                        end else if (r_ei_pending) begin
                            r_ime <= 1'b1;
                        end
                        r_ei_pending <= 1'b0;
                    end
                    // A fresh EI re-arms pending even if this fetch consumed it.
                    if (i_EI) begin
                        r_ei_pending <= 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        w_x_active = 4'b0001 << r_ir[7:6];
        if (r_cb_mode || r_int_dispatch) begin
            w_x_active = 4'b0000;
        end
    end

    assign o_Cycle_Step   = r_step;
    assign o_Cycle_Count  = r_count;
    assign o_IR           = r_ir;
    assign o_X_Active     = w_x_active;
    assign o_CB_Active    = r_cb_mode & ~r_int_dispatch;
    assign o_Y            = 8'h01 << r_ir[5:3];
    assign o_Z            = 8'h01 << r_ir[2:0];
    assign o_P            = 4'b0001 << r_ir[5:4];
    assign o_Q            = 2'b01 << r_ir[3];
    assign o_CB_Mode      = r_cb_mode;
    assign o_IME          = r_ime;
    assign o_Int_Dispatch = r_int_dispatch;
    assign o_Count_Error  = r_count_error;

endmodule
